// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
//  Module      : program_loader
//  Description : Byte-serial program loader and instruction store for the
//                8-bit CPU. A length-prefixed byte stream (header N, then
//                three bytes per instruction) arrives over a valid/ready
//                handshake. Every three bytes are packed into one 20-bit
//                instruction and written into a small program store, which
//                the control unit reads through a combinational fetch port.
//  Revision    : 1.0  - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk            in   1        single clock, rising edge
//    rst            in   1        asynchronous, active-high reset
//    i_start        in   1        pulse: clear store, begin a load session
//    i_byte_in      in   8        stream byte
//    i_byte_valid   in   1        i_byte_in is valid
//    o_byte_ready   out  1        loader accepts a byte this cycle
//    i_fetch_addr   in   4        control-unit fetch address (PC)
//    o_fetch_instr  out  INSTR_W  store[i_fetch_addr], 0 when out of range
//    o_prog_ready   out  1        program fully loaded
//    o_instr_count  out  4        instructions written so far
//    o_load_error   out  1        session aborted on a framing error
//  Instruction layout: {opcode[19:16], operand1[15:8], operand2[7:0]}
//    byte 0 -> [7:0], byte 1 -> [15:8], byte 2[3:0] -> [19:16]
//    byte 2[7:4] must be zero.
// ============================================================================
module program_loader #(
   parameter int NUM_INSTR = 8,   // store depth, at most 15
   parameter int INSTR_W   = 20   // instruction width, layout assumes 20
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_start,
   input  logic [7:0]         i_byte_in,
   input  logic               i_byte_valid,
   output logic               o_byte_ready,
   input  logic [3:0]         i_fetch_addr,
   output logic [INSTR_W-1:0] o_fetch_instr,
   output logic               o_prog_ready,
   output logic [3:0]         o_instr_count,
   output logic               o_load_error
);

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_CLEAR  = 4'd1,
      S_HEADER = 4'd2,
      S_B0     = 4'd3,
      S_B1     = 4'd4,
      S_B2     = 4'd5,
      S_WRITE  = 4'd6,
      S_DONE   = 4'd7,
      S_ERROR  = 4'd8
   } state_t;

   localparam logic [7:0] c_max_n = 8'(NUM_INSTR);

   state_t             r_state;
   logic               r_byte_ready;
   logic               r_prog_ready;
   logic               r_load_error;
   logic [3:0]         r_count;
   logic [3:0]         r_n;
   logic [INSTR_W-1:0] r_asm;
   logic [INSTR_W-1:0] r_store [NUM_INSTR];

   logic               w_xfer;
   logic [3:0]         w_count_next;
   logic [INSTR_W-1:0] w_fetch_instr;

   assign w_xfer       = i_byte_valid & r_byte_ready;
   assign w_count_next = r_count + 4'd1;

   // ------------------------------------------------------------------------
   // Control FSM, assembly register and program store.
   // byte_ready is registered: it is set on the same edge that enters
   // HEADER/B0/B1/B2, so it is a pure function of the current state.
   // The store and status are cleared on the edge that samples i_start,
   // so the whole CLEAR cycle already shows an empty store.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_byte_ready <= 1'b0;
         r_prog_ready <= 1'b0;
         r_load_error <= 1'b0;
         r_count      <= 4'd0;
         r_n          <= 4'd0;
         r_asm        <= '0;
         for (int i = 0; i < NUM_INSTR; i++) begin
            r_store[i] <= '0;
         end
      end else if (i_start) begin
         // Start wins in every state; a byte offered now is dropped because
         // the transfer is never acted upon in this branch.
         r_state      <= S_CLEAR;
         r_byte_ready <= 1'b0;
         r_prog_ready <= 1'b0;
         r_load_error <= 1'b0;
         r_count      <= 4'd0;
         r_n          <= 4'd0;
         r_asm        <= '0;
         for (int i = 0; i < NUM_INSTR; i++) begin
            r_store[i] <= '0;
         end
      end else begin
         case (r_state)
            S_IDLE: begin
               r_byte_ready <= 1'b0;
            end

            S_CLEAR: begin
               r_state      <= S_HEADER;
               r_byte_ready <= 1'b1;
            end

            S_HEADER: begin
               if (w_xfer) begin
                  if ((i_byte_in == 8'd0) || (i_byte_in > c_max_n)) begin
                     r_state      <= S_ERROR;
                     r_byte_ready <= 1'b0;
                     r_load_error <= 1'b1;
                  end else begin
                     // Range check above guarantees N fits in 4 bits.
                     r_n     <= i_byte_in[3:0];
                     r_state <= S_B0;
                  end
               end
            end

            S_B0: begin
               if (w_xfer) begin
                  r_asm[7:0] <= i_byte_in;
                  r_state    <= S_B1;
               end
            end

            S_B1: begin
               if (w_xfer) begin
                  r_asm[15:8] <= i_byte_in;
                  r_state     <= S_B2;
               end
            end

            S_B2: begin
               if (w_xfer) begin
                  r_byte_ready <= 1'b0;
                  if (i_byte_in[7:4] != 4'd0) begin
                     r_state      <= S_ERROR;
                     r_load_error <= 1'b1;
                  end else begin
                     r_asm[19:16] <= i_byte_in[3:0];
                     r_state      <= S_WRITE;
                  end
               end
            end

            S_WRITE: begin
               // r_count < N <= NUM_INSTR here, so the write never wraps.
               for (int i = 0; i < NUM_INSTR; i++) begin
                  if (r_count == 4'(i)) begin
                     r_store[i] <= r_asm;
                  end
               end
               r_count <= w_count_next;
               if (w_count_next == r_n) begin
                  r_state      <= S_DONE;
                  r_byte_ready <= 1'b0;
                  r_prog_ready <= 1'b1;
               end else begin
                  r_state      <= S_B0;
                  r_byte_ready <= 1'b1;
               end
            end

            S_DONE: begin
               r_byte_ready <= 1'b0;
            end

            S_ERROR: begin
               r_byte_ready <= 1'b0;
               r_prog_ready <= 1'b0;
            end

            default: begin
               r_state      <= S_IDLE;
               r_byte_ready <= 1'b0;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Combinational fetch port; addresses beyond the store read as zero.
   // ------------------------------------------------------------------------
   always_comb begin
      w_fetch_instr = '0;
      for (int i = 0; i < NUM_INSTR; i++) begin
         if (i_fetch_addr == 4'(i)) begin
            w_fetch_instr = r_store[i];
         end
      end
   end

   assign o_byte_ready  = r_byte_ready;
   assign o_fetch_instr = w_fetch_instr;
   assign o_prog_ready  = r_prog_ready;
   assign o_instr_count = r_count;
   assign o_load_error  = r_load_error;

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_program_loader
//  Description : Self-checking bench for program_loader. Scenario table,
//                hand-written multi-cycle sequences (latency, backpressure,
//                abort, mid-session reset) and randomized streams checked
//                against a stream-level reference model.
//  Revision    : 1.0  - initial release
// ============================================================================
module tb_program_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_start;
   logic [7:0]  i_byte_in;
   logic        i_byte_valid;
   logic        o_byte_ready;
   logic [3:0]  i_fetch_addr;
   logic [19:0] o_fetch_instr;
   logic        o_prog_ready;
   logic [3:0]  o_instr_count;
   logic        o_load_error;

   program_loader #(
      .NUM_INSTR (8),
      .INSTR_W   (20)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .i_start       (i_start),
      .i_byte_in     (i_byte_in),
      .i_byte_valid  (i_byte_valid),
      .o_byte_ready  (o_byte_ready),
      .i_fetch_addr  (i_fetch_addr),
      .o_fetch_instr (o_fetch_instr),
      .o_prog_ready  (o_prog_ready),
      .o_instr_count (o_instr_count),
      .o_load_error  (o_load_error)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Current stream and expected results.
   logic [7:0]  q [$];
   logic [19:0] e_store [16];
   logic [3:0]  e_cnt;
   logic        e_rdy;
   logic        e_err;
   int          acc_cnt;
   logic        wr_ok;

   typedef struct {
      int          len;
      logic [55:0] bytes;   // first stream byte in the top byte
      logic        err;
      logic        rdy;
      logic [3:0]  cnt;
      logic [19:0] s0;
      logic [19:0] s1;
   } vec_t;

   vec_t tv [6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      i_start = 1'b1;
      step();
      i_start = 1'b0;
   endtask

   // Reference model: derive the expected store and status directly from
   // the stream rules (header range, 3-byte packing, byte-2 high nibble).
   function automatic void model();
      int n;
      logic [7:0] b2;
      for (int a = 0; a < 16; a++) e_store[a] = 20'h0;
      e_cnt = 4'd0;
      e_rdy = 1'b0;
      e_err = 1'b0;
      n = int'(q[0]);
      if (n == 0 || n > 8) begin
         e_err = 1'b1;
         return;
      end
      for (int k = 0; k < n; k++) begin
         b2 = q[3 + 3*k];
         if (b2[7:4] != 4'h0) begin
            e_err = 1'b1;
            return;
         end
         e_store[k] = {b2[3:0], q[2 + 3*k], q[1 + 3*k]};
         e_cnt = 4'(k + 1);
      end
      e_rdy = 1'b1;
   endfunction

   // Offer q to the DUT. mode 0: continuous valid, 1: alternating, 2: random.
   // Also records that byte_ready is low right after every third data byte.
   task automatic send(input int mode);
      int   idx;
      int   budget;
      logic v;
      logic acc;
      idx     = 0;
      budget  = 0;
      acc_cnt = 0;
      wr_ok   = 1'b1;
      while (idx < q.size() && budget < 400 && !o_load_error) begin
         if (mode == 0)      v = 1'b1;
         else if (mode == 1) v = (budget % 2 == 0);
         else                v = ($urandom_range(0, 2) != 0);
         i_byte_valid = v;
         i_byte_in    = v ? q[idx] : 8'($urandom);
         acc          = v & o_byte_ready;
         step();
         if (acc) begin
            idx++;
            acc_cnt++;
            if (idx >= 4 && ((idx - 1) % 3) == 0 && o_byte_ready !== 1'b0) wr_ok = 1'b0;
         end
         budget++;
      end
      i_byte_valid = 1'b0;
   endtask

   task automatic wait_end();
      int n;
      n = 0;
      while (!(o_prog_ready || o_load_error) && n < 20) begin
         step();
         n++;
      end
   endtask

   task automatic check_store(input string name);
      int bad;
      bad = 0;
      for (int a = 0; a < 16; a++) begin
         i_fetch_addr = 4'(a);
         #1;
         if (o_fetch_instr !== e_store[a]) bad++;
      end
      chk(name, bad, 0);
      step();
   endtask

   task automatic check_all(input string name);
      chk({name, "_err"},  o_load_error,  e_err);
      chk({name, "_rdy"},  o_prog_ready,  e_rdy);
      chk({name, "_cnt"},  o_instr_count, e_cnt);
      chk({name, "_brdy"}, o_byte_ready,  1'b0);
      check_store({name, "_store"});
   endtask

   task automatic load_vec(input vec_t v);
      q.delete();
      for (int k = 0; k < v.len; k++) q.push_back(v.bytes[55 - 8*k -: 8]);
   endtask

   task automatic load_nominal();
      q.delete();
      q = '{8'h02, 8'h34, 8'h12, 8'h05, 8'h01, 8'h00, 8'h03};
   endtask

   initial begin
      int   idx;
      logic acc;
      int   n;
      int   kind;
      int   bad_k;

      rst          = 1'b1;
      i_start      = 1'b0;
      i_byte_in    = 8'h00;
      i_byte_valid = 1'b0;
      i_fetch_addr = 4'd0;

      tv[0] = '{7, 56'h02_34_12_05_01_00_03, 1'b0, 1'b1, 4'd2, 20'h51234, 20'h30001};
      tv[1] = '{1, 56'h00_00_00_00_00_00_00, 1'b1, 1'b0, 4'd0, 20'h00000, 20'h00000};
      tv[2] = '{1, 56'h09_00_00_00_00_00_00, 1'b1, 1'b0, 4'd0, 20'h00000, 20'h00000};
      tv[3] = '{4, 56'h01_AA_BB_15_00_00_00, 1'b1, 1'b0, 4'd0, 20'h00000, 20'h00000};
      tv[4] = '{4, 56'h01_FF_EE_0F_00_00_00, 1'b0, 1'b1, 4'd1, 20'hFEEFF, 20'h00000};
      tv[5] = '{7, 56'h02_11_22_03_44_55_F6, 1'b1, 1'b0, 4'd1, 20'h32211, 20'h00000};

      step();
      step();
      rst = 1'b0;
      step();

      // Reset state
      chk("reset_brdy", o_byte_ready,  1'b0);
      chk("reset_prdy", o_prog_ready,  1'b0);
      chk("reset_cnt",  o_instr_count, 4'd0);
      chk("reset_err",  o_load_error,  1'b0);
      for (int a = 0; a < 16; a++) e_store[a] = 20'h0;
      check_store("reset_store");

      // Best-case latency: start at E0, prog_ready after E10 for N=2.
      load_nominal();
      idx          = 0;
      i_start      = 1'b1;
      i_byte_valid = 1'b1;
      i_byte_in    = q[0];
      for (int e = 0; e <= 10; e++) begin
         acc = o_byte_ready & i_byte_valid & ~i_start;
         step();
         i_start = 1'b0;
         if (acc) idx++;
         if (idx < q.size()) i_byte_in = q[idx];
         else                i_byte_valid = 1'b0;
         if (e == 9) chk("lat_before_E10", o_prog_ready, 1'b0);
      end
      i_byte_valid = 1'b0;
      chk("lat_E10",   o_prog_ready, 1'b1);
      chk("lat_bytes", idx, 7);

      // Scenario table
      for (int t = 0; t < 6; t++) begin
         load_vec(tv[t]);
         do_start();
         send(0);
         wait_end();
         for (int a = 0; a < 16; a++) e_store[a] = 20'h0;
         e_store[0] = tv[t].s0;
         e_store[1] = tv[t].s1;
         e_cnt      = tv[t].cnt;
         e_rdy      = tv[t].rdy;
         e_err      = tv[t].err;
         check_all($sformatf("vec%0d", t));
      end

      // Backpressure: alternating valid, identical result.
      load_nominal();
      model();
      do_start();
      send(1);
      wait_end();
      chk("bp_accepted", acc_cnt, 7);
      chk("bp_write_brdy", wr_ok, 1'b1);
      check_all("bp");

      // Abort: start with a byte in B0 after the first instruction's write.
      q.delete();
      q = '{8'h02, 8'h34, 8'h12, 8'h05};
      do_start();
      send(0);
      step();
      chk("abort_pre_cnt", o_instr_count, 4'd1);
      i_start      = 1'b1;
      i_byte_valid = 1'b1;
      i_byte_in    = 8'h01;
      step();
      i_start      = 1'b0;
      i_byte_valid = 1'b0;
      chk("abort_cnt",  o_instr_count, 4'd0);
      chk("abort_brdy_clear", o_byte_ready, 1'b0);
      step();
      chk("abort_brdy_header", o_byte_ready, 1'b1);
      i_fetch_addr = 4'd0;
      #1;
      chk("abort_store0", o_fetch_instr, 20'h0);
      load_nominal();
      model();
      send(0);
      wait_end();
      check_all("abort_reload");

      // Mid-session reset after a complete program was loaded.
      load_nominal();
      do_start();
      send(0);
      wait_end();
      q.delete();
      q = '{8'h02, 8'h77, 8'h66, 8'h05, 8'h99};
      do_start();
      send(0);
      rst = 1'b1;
      #1;
      chk("rst_outputs", {o_byte_ready, o_prog_ready, o_instr_count, o_load_error}, 7'd0);
      for (int a = 0; a < 16; a++) e_store[a] = 20'h0;
      check_store("rst_store");
      rst = 1'b0;
      step();
      chk("rst_idle_brdy", o_byte_ready, 1'b0);

      // Randomized streams against the reference model.
      for (int it = 0; it < 30; it++) begin
         q.delete();
         kind = $urandom_range(0, 9);
         if (kind == 0) n = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(9, 255);
         else           n = $urandom_range(1, 8);
         q.push_back(8'(n));
         if (n >= 1 && n <= 8) begin
            bad_k = (kind == 1) ? $urandom_range(0, n - 1) : -1;
            for (int k = 0; k < n; k++) begin
               q.push_back(8'($urandom));
               q.push_back(8'($urandom));
               if (k == bad_k) q.push_back({4'($urandom_range(1, 15)), 4'($urandom)});
               else            q.push_back({4'h0, 4'($urandom)});
               if (k == bad_k) break;
            end
         end
         model();
         do_start();
         send($urandom_range(0, 2));
         wait_end();
         chk($sformatf("rand%0d_accepted", it), acc_cnt, q.size());
         check_all($sformatf("rand%0d", it));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/program_loader.md
# program_loader

Byte-serial program loader and instruction store for the 8-bit CPU. It accepts a length-prefixed byte stream over a valid/ready handshake and packs every three bytes into one 20-bit instruction word. Each word is written into an 8-entry program store. The control unit fetches from this store through a combinational read port, and `prog_ready` tells it the program is complete and fetch may begin.

## Interface
- `NUM_INSTR`, default 8: store depth; must be ≤ 15 so that `instr_count` fits in 4 bits.
- `INSTR_W`, default 20: instruction width; {opcode[19:16], operand1[15:8], operand2[7:0]}.
- `clk` in 1: single clock, all state changes on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle pulse; clears the store and begins a load session.
- `byte_in` in 8: stream byte.
- `byte_valid` in 1: `byte_in` is valid.
- `byte_ready` out 1: loader accepts a byte this cycle.
- `fetch_addr` in 4: control-unit fetch address (PC).
- `fetch_instr` out 20: store[`fetch_addr`]; combinational.
- `prog_ready` out 1: program fully loaded.
- `instr_count` out 4: instructions written so far.
- `load_error` out 1: session aborted on a framing error.

## Operation
- Stream format: header byte N (instruction count), then 3 bytes per instruction.
  - Byte 0 → bits[7:0], byte 1 → bits[15:8], byte 2[3:0] → bits[19:16].
  - Byte 2[7:4] must be 0.
- Transfer: a byte is consumed on a clock edge where `byte_valid` & `byte_ready`.
- `byte_ready` is a Moore output: 1 only in HEADER, B0, B1, B2.
- States and transitions:
  - IDLE: `start` → CLEAR.
  - CLEAR (1 cycle): zero all entries; `instr_count`=0, `prog_ready`=0, `load_error`=0 → HEADER.
  - HEADER: on transfer, latch N.
    - N==0 or N>NUM_INSTR → ERROR.
    - Otherwise → B0.
  - B0 → B1 → B2: each advances on transfer into a 20-bit assembly register.
    - In B2, byte[7:4]≠0 → ERROR.
    - Otherwise → WRITE.
  - WRITE (1 cycle, no transfer): store[`instr_count`] ← assembly; `instr_count`+1.
    - If new count == N → DONE.
    - Otherwise → B0.
  - DONE: `prog_ready`=1, holds; `start` → CLEAR.
  - ERROR: `load_error`=1, `prog_ready`=0, holds; `start` → CLEAR.
- `start` has priority in every state; a mid-session `start` aborts to CLEAR. A byte presented in that same cycle is discarded, and the sender must resend the whole stream.
- Fetch:
  - `fetch_instr` = store[`fetch_addr`] at any time, including mid-load; unwritten entries read 0.
  - `fetch_addr` ≥ NUM_INSTR reads 20'h0.
- No wrap-around: the store is never written beyond N entries, and N ≤ NUM_INSTR is enforced.

## Timing
- Reset values: state IDLE, all store entries 0, `byte_ready`=0, `prog_ready`=0, `instr_count`=0, `load_error`=0, assembly register 0.
- Reset asserted mid-session: immediate return to the reset values above; no partial program survives.
- Best-case latency, with `byte_valid` held high: `start` sampled at edge E0 → CLEAR after E0 → HEADER after E1 → header consumed at E2. Each instruction then takes 4 edges. `prog_ready` is high after edge E(2+4N); for N=1, after E6.
- Throughput: 3 bytes per 4 cycles. `byte_valid` gaps stall the FSM with no loss.
- `instr_count` updates on the WRITE edge. An entry is readable on `fetch_instr` in the cycle after its WRITE.
- `load_error` is set on the edge that consumes the offending byte and holds until `start` or `rst`.

## Test plan
- Reset: assert `rst` mid-stream → all outputs 0, `fetch_instr`=0 for addresses 0–15, state IDLE (`byte_ready`=0).
- Nominal: `start`, then stream 02, 34,12,05, 01,00,03 with continuous valid → `prog_ready` after edge E10. Expect store[0]=20'h51234, store[1]=20'h30001, `instr_count`=2, `fetch_addr`=2 → 0.
- Backpressure: same stream with `byte_valid` toggling 1-0-1-0 → identical store contents. Each byte is accepted exactly once, and `byte_ready`=0 during WRITE.
- Header errors: N=00 and N=09 (each after `start`) → `load_error`=1, `prog_ready`=0, `instr_count`=0, `byte_ready`=0.
- Framing error: byte 2 = 8'h15 → `load_error`=1. A following `start` plus a valid stream clears the error and loads correctly.
- Abort: `start` pulsed after 4 bytes of a 2-instruction stream (together with `byte_valid`) → that byte is dropped, store cleared, `instr_count`=0. A fresh stream then loads normally.
